onehot_decoder_seq: RTL
=======================

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 The block SHALL have a parameter IN_W, default 3, giving the code width; OUT_W = 2**IN_W, legal IN_W range 1..6.
REQ-002 The block SHALL have a parameter ACTIVE_LOW, default 0; 1 means active output bit is 0 and all inactive bits are 1.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, with reset synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an upstream code is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the offered code this cycle.
REQ-007 The block SHALL have port mode, input, 1, sampled on accept: 0 = single decode, 1 = sweep.
REQ-008 The block SHALL have port in, input, IN_W, holding the code to decode, or the sweep start code.
REQ-009 The block SHALL have port out, output, OUT_W, the registered one-hot (or one-cold) word.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out holds a valid word.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream takes out this cycle.
REQ-012 The block SHALL have port sweep_done, output, 1, a one-cycle registered pulse when a sweep completes.

Function
REQ-013 An accept SHALL occur on a clk edge where in_valid && in_ready; a transfer SHALL occur on a clk edge where out_valid && out_ready.
REQ-014 The block SHALL implement states IDLE and SWEEP.
REQ-015 in_ready SHALL be combinational and equal to (state==IDLE) && (!out_valid || out_ready) && !rst.
REQ-016 Accept in IDLE with mode=0 SHALL load out with bit[in] active and set out_valid next cycle, giving a latency of 1 clk; the state SHALL remain IDLE.
REQ-017 Accept in IDLE with mode=1 SHALL load out with bit[in] active, set out_valid, load cnt=in, and enter SWEEP.
REQ-018 In SWEEP, each transfer with cnt < OUT_W-1 SHALL increment cnt and load out with bit[cnt+1] active, keeping out_valid high, so that back-to-back transfers occur every cycle.
REQ-019 In SWEEP, the transfer with cnt == OUT_W-1 SHALL clear out_valid, return the block to IDLE, and assert sweep_done for exactly the next cycle.
REQ-020 A sweep started with in = OUT_W-1 SHALL produce exactly one word, then sweep_done.
REQ-021 The counter cnt SHALL be IN_W bits wide and SHALL never wrap within a sweep.
REQ-022 While out_valid && !out_ready, out and out_valid SHALL hold stable, with no accept and no advance.
REQ-023 A transfer in IDLE with no simultaneous accept SHALL clear out_valid and drive out to the all-inactive word.
REQ-024 A transfer in IDLE with a simultaneous accept SHALL load the new word with no bubble, and out_valid SHALL stay 1.
REQ-025 Whenever out_valid=0, out SHALL be the all-inactive word: all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1.
REQ-026 When out_valid=1, out SHALL contain exactly one active bit.
REQ-027 in and mode SHALL be ignored while in_ready=0, including during SWEEP.

Reset
REQ-028 When rst=1 at a clk edge, the block SHALL set state=IDLE, cnt=0, out_valid=0, out to the all-inactive word, and sweep_done=0.
REQ-029 rst asserted mid-sweep SHALL abort the sweep without a sweep_done pulse, and the first post-reset accept SHALL behave as from power-up.
REQ-030 in_ready SHALL be 0 during rst and SHALL be 1 in the first cycle after rst deasserts.

Verification (IN_W=3, ACTIVE_LOW=0 unless stated)
REQ-031 Single-decode case: mode=0, in=3'b101, out_ready=1 -> one cycle later out=8'b00100000 and out_valid=1; next cycle out=8'b00000000 and out_valid=0.
REQ-032 Exhaustive single-decode case: codes 0..7 presented back-to-back with out_ready=1 -> out = 8'h01, 02, 04, ... 80 on consecutive cycles, with out_valid continuously 1 and no bubbles.
REQ-033 Sweep case: mode=1, in=3'd5, out_ready=1 -> out = 8'h20, 8'h40, 8'h80 on 3 consecutive cycles, then sweep_done=1 for one cycle; in_ready=0 throughout the sweep.
REQ-034 Backpressure case: sweep from 0 with out_ready toggling 1,0,0,1,... -> out holds during stalls, all 8 codes are delivered in order exactly once, and sweep_done follows the 8th transfer.
REQ-035 Reset-mid-sweep case: rst=1 after the 2nd transfer -> next cycle out=0, out_valid=0, sweep_done=0, in_ready=1 after release; a new mode=0, in=3 accept then yields 8'h08.
REQ-036 ACTIVE_LOW=1 case: idle -> out=8'hFF; mode=0, in=3'd0 -> out=8'hFE.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered one-hot/one-cold decoder with single-decode and sweep modes
module onehot_decoder_seq #(
  parameter int IN_W = 3,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sweep_done
);
  typedef enum logic {IDLE, SWEEP} state_t;
  localparam logic [OUT_W-1:0] idle_word = {OUT_W{ACTIVE_LOW}};
  localparam logic [IN_W-1:0] last = {IN_W{1'b1}};
  state_t state, state_next;
  logic [IN_W-1:0] cnt, cnt_next;
  logic [OUT_W-1:0] out_next;
  logic out_valid_next, sweep_done_next, accept, xfer;
  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] c);
    logic [OUT_W-1:0] h;
    h = OUT_W'(1) << c;
    return ACTIVE_LOW ? ~h : h;
  endfunction
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  // next state: accept loads a word, the final transfer of a sweep or an idle transfer empties the output, other sweep transfers advance
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    out_next = out;
    out_valid_next = out_valid;
    sweep_done_next = 1'b0;
    if (accept) begin
      out_next = decode(in);
      out_valid_next = 1'b1;
      state_next = mode ? SWEEP : IDLE;
      cnt_next = mode ? in : cnt;
    end else if (xfer && (state == IDLE || cnt == last)) begin
      out_next = idle_word;
      out_valid_next = 1'b0;
      state_next = IDLE;
      sweep_done_next = (state == SWEEP);
    end else if (xfer) begin
      cnt_next = cnt + 1'b1;
      out_next = decode(cnt + 1'b1);
    end
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out <= idle_word;
      out_valid <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      out <= out_next;
      out_valid <= out_valid_next;
      sweep_done <= sweep_done_next;
    end
  end
endmodule
